// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: 5-8 data bits, none/even/odd parity, 1 or 2 stop bits.
// Define UART_TX_CFG_FIFO_EN for a FIFO_DEPTH-entry input FIFO; otherwise one holding register.
module uart_tx_cfg #(
    parameter int unsigned NB_DATA_MAX = 8,
    parameter int unsigned S_TICK      = 16,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   s_tick,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [NB_DATA_MAX-1:0] in_data,
    input  logic [1:0]             cfg_nbits,
    input  logic [1:0]             cfg_parity,
    input  logic                   cfg_stop2,
    output logic                   tx_serial,
    output logic                   tx_busy,
    output logic                   tx_done_tick
);

    localparam int unsigned TW = $clog2(2 * S_TICK);
    localparam logic [TW-1:0] TickLast  = TW'(S_TICK - 1);
    localparam logic [TW-1:0] TickLast2 = TW'(2 * S_TICK - 1);

    if (NB_DATA_MAX < 5 || NB_DATA_MAX > 8 || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_check
        $error("uart_tx_cfg: illegal NB_DATA_MAX or FIFO_DEPTH");
    end

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    logic                   buf_empty;
    logic                   buf_full;
    logic                   buf_push;
    logic                   buf_pop;
    logic [NB_DATA_MAX-1:0] buf_head;

    assign in_ready = !buf_full;
    assign buf_push = in_valid && !buf_full;

`ifdef UART_TX_CFG_FIFO_EN
    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    logic [NB_DATA_MAX-1:0] mem_q [FIFO_DEPTH];
    logic [NB_DATA_MAX-1:0] mem_d [FIFO_DEPTH];
    logic [AW:0]            wr_ptr_q, wr_ptr_d;
    logic [AW:0]            rd_ptr_q, rd_ptr_d;

    // Pointers carry one extra wrap bit to tell full from empty.
    assign buf_empty = (wr_ptr_q == rd_ptr_q);
    assign buf_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign buf_head  = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q + (AW+1)'(buf_push);
        rd_ptr_d = rd_ptr_q + (AW+1)'(buf_pop);
        if (buf_push) begin
            mem_d[wr_ptr_q[AW-1:0]] = in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end
`else
    logic                   hold_valid_q, hold_valid_d;
    logic [NB_DATA_MAX-1:0] hold_q, hold_d;

    assign buf_empty = !hold_valid_q;
    assign buf_full  = hold_valid_q;
    assign buf_head  = hold_q;

    always_comb begin
        hold_valid_d = hold_valid_q;
        hold_d       = hold_q;
        if (buf_pop) begin
            hold_valid_d = 1'b0;
        end
        if (buf_push) begin
            hold_valid_d = 1'b1;
            hold_d       = in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_valid_q <= 1'b0;
            hold_q       <= '0;
        end else begin
            hold_valid_q <= hold_valid_d;
            hold_q       <= hold_d;
        end
    end
`endif

    state_e          state_q, state_d;
    logic [TW-1:0]   tick_q, tick_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      data_q, data_d;
    logic [1:0]      nbits_q, nbits_d;
    logic [1:0]      par_q, par_d;
    logic            stop2_q, stop2_d;
    logic            acc_q, acc_d;
    logic            tx_q, tx_d;
    logic            done_q, done_d;

    logic            tick_hit;
    logic            stop_hit;
    logic            par_en;
    logic            par_bit;
    logic [2:0]      bit_last;

    assign tick_hit = s_tick && (tick_q == TickLast);
    assign stop_hit = s_tick && (tick_q == (stop2_q ? TickLast2 : TickLast));
    assign par_en   = (par_q == 2'b01) || (par_q == 2'b10);
    assign bit_last = {1'b0, nbits_q} + 3'd4;
    // Even parity repeats the running XOR; odd parity inverts it.
    assign par_bit  = (par_q == 2'b01) ? (acc_q ^ data_q[0]) : ~(acc_q ^ data_q[0]);

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        data_d  = data_q;
        nbits_d = nbits_q;
        par_d   = par_q;
        stop2_d = stop2_q;
        acc_d   = acc_q;
        tx_d    = tx_q;
        done_d  = 1'b0;
        buf_pop = 1'b0;

        if (state_q != StIdle && s_tick) begin
            tick_d = tick_q + TW'(1);
        end

        unique case (state_q)
            StIdle: begin
                tx_d   = 1'b1;
                tick_d = '0;
                if (!buf_empty) begin
                    buf_pop = 1'b1;
                    state_d = StStart;
                    tx_d    = 1'b0;
                end
            end
            StStart: begin
                if (tick_hit) begin
                    state_d = StData;
                    tick_d  = '0;
                    bit_d   = '0;
                    acc_d   = 1'b0;
                    tx_d    = data_q[0];
                end
            end
            StData: begin
                if (tick_hit) begin
                    tick_d = '0;
                    acc_d  = acc_q ^ data_q[0];
                    if (bit_q == bit_last) begin
                        if (par_en) begin
                            state_d = StParity;
                            tx_d    = par_bit;
                        end else begin
                            state_d = StStop;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_d  = bit_q + 3'd1;
                        data_d = data_q >> 1;
                        tx_d   = data_q[1];
                    end
                end
            end
            StParity: begin
                if (tick_hit) begin
                    state_d = StStop;
                    tick_d  = '0;
                    tx_d    = 1'b1;
                end
            end
            StStop: begin
                if (stop_hit) begin
                    done_d = 1'b1;
                    tick_d = '0;
                    if (!buf_empty) begin
                        buf_pop = 1'b1;
                        state_d = StStart;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = StIdle;
                        tx_d    = 1'b1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                tx_d    = 1'b1;
            end
        endcase

        // Frame configuration is captured only when a byte leaves the buffer.
        if (buf_pop) begin
            data_d  = 8'(buf_head);
            nbits_d = cfg_nbits;
            par_d   = cfg_parity;
            stop2_d = cfg_stop2;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            tick_q  <= '0;
            bit_q   <= '0;
            data_q  <= '0;
            nbits_q <= '0;
            par_q   <= '0;
            stop2_q <= 1'b0;
            acc_q   <= 1'b0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            data_q  <= data_d;
            nbits_q <= nbits_d;
            par_q   <= par_d;
            stop2_q <= stop2_d;
            acc_q   <= acc_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

    assign tx_serial    = tx_q;
    assign tx_busy      = (state_q != StIdle);
    assign tx_done_tick = done_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg: framing vectors, back-to-back frames, mid-frame reset,
// mid-frame config change and a slow baud tick. Handles both buffer builds.
module tb_uart_tx_cfg;

    logic       clk = 1'b0;
    logic       reset;
    logic       s_tick;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [1:0] cfg_nbits;
    logic [1:0] cfg_parity;
    logic       cfg_stop2;
    logic       tx_serial;
    logic       tx_busy;
    logic       tx_done_tick;

    int errors = 0;
    int checks = 0;
    int done_total = 0;
    int tick_every = 1;

    always #5 clk = ~clk;

    uart_tx_cfg #(
        .NB_DATA_MAX(8),
        .S_TICK     (16),
        .FIFO_DEPTH (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .s_tick      (s_tick),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .cfg_nbits   (cfg_nbits),
        .cfg_parity  (cfg_parity),
        .cfg_stop2   (cfg_stop2),
        .tx_serial   (tx_serial),
        .tx_busy     (tx_busy),
        .tx_done_tick(tx_done_tick)
    );

    initial begin
        int div;
        div    = 0;
        s_tick = 1'b0;
        forever begin
            @(negedge clk);
            div    = (div + 1 >= tick_every) ? 0 : div + 1;
            s_tick = (div == 0);
        end
    end

    always @(posedge clk) begin
        if (tx_done_tick === 1'b1) done_total++;
    end

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the byte was accepted.
    task automatic push_byte(input logic [7:0] d);
        int w;
        w = 0;
        while (in_ready !== 1'b1 && w < 400) begin
            @(negedge clk);
            w++;
        end
        check("push_wait_bound", int'(w < 400), 1);
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // n=0 is the first negedge with the line low; bits sampled mid-slot.
    task automatic capture(input int nb, output logic [15:0] frame, output int len,
                           output int lat, output int done_end);
        int slot;
        slot     = 16 * tick_every;
        frame    = '0;
        lat      = 0;
        len      = -1;
        done_end = 0;
        while (tx_serial !== 1'b0 && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        for (int n = 0; n < nb * slot + 40; n++) begin
            if (tx_busy !== 1'b1) begin
                len      = n;
                done_end = int'(tx_done_tick === 1'b1);
                break;
            end
            if (n % slot == slot / 2 && n / slot < nb) frame[n / slot] = tx_serial;
            @(negedge clk);
        end
    endtask

    typedef struct {
        logic [7:0]  data;
        logic [1:0]  nb;
        logic [1:0]  par;
        logic        st2;
        int          bits;
        logic [15:0] frame;
    } vec_t;

`ifdef UART_TX_CFG_FIFO_EN
    localparam int Acc = 5;
    localparam logic [5:0] BurstPat = 6'b011111;
`else
    localparam int Acc = 2;
    localparam logic [5:0] BurstPat = 6'b000101;
`endif

    initial begin
        vec_t        vecs [6];
        logic [7:0]  burst [6];
        logic [7:0]  exp_bytes [5];
        logic [15:0] frame;
        logic [49:0] line;
        logic [16:0] line2;
        logic [16:0] exp2;
        logic [9:0]  exp_f;
        int          len, lat, done_end, d0, gap, lows, k;

        // Line image: bit i = slot i (start, data LSB first, parity, stop bits).
        vecs[0] = '{8'h55, 2'b11, 2'b00, 1'b0, 10, 16'h02AA};  // 8N1
        vecs[1] = '{8'h83, 2'b10, 2'b01, 1'b0, 10, 16'h0206};  // 7E1, bit 7 dropped
        vecs[2] = '{8'hFF, 2'b00, 2'b10, 1'b1,  9, 16'h01BE};  // 5O2
        vecs[3] = '{8'hA5, 2'b01, 2'b11, 1'b0,  8, 16'h00CA};  // 6N1 via parity code 11
        vecs[4] = '{8'h3C, 2'b11, 2'b10, 1'b1, 12, 16'h0E78};  // 8O2, parity 1
        vecs[5] = '{8'h00, 2'b00, 2'b01, 1'b0,  8, 16'h0080};  // 5E1, all zero

        burst[0] = 8'h11; burst[1] = 8'h22; burst[2] = 8'h33;
        burst[3] = 8'h44; burst[4] = 8'h55; burst[5] = 8'h66;

        reset      = 1'b1;
        in_valid   = 1'b0;
        in_data    = '0;
        cfg_nbits  = 2'b11;
        cfg_parity = 2'b00;
        cfg_stop2  = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_tx_serial", int'(tx_serial), 1);
        check("rst_tx_busy", int'(tx_busy), 0);
        check("rst_done", int'(tx_done_tick), 0);
        check("rst_in_ready", int'(in_ready), 1);
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            cfg_nbits  = vecs[i].nb;
            cfg_parity = vecs[i].par;
            cfg_stop2  = vecs[i].st2;
            d0 = done_total;
            push_byte(vecs[i].data);
            capture(vecs[i].bits, frame, len, lat, done_end);
            check($sformatf("vec%0d_frame", i), int'(frame), int'(vecs[i].frame));
            check($sformatf("vec%0d_len", i), len, 16 * vecs[i].bits);
            check($sformatf("vec%0d_start_latency", i), lat, 1);
            check($sformatf("vec%0d_done_at_end", i), done_end, 1);
            repeat (3) @(negedge clk);
            check($sformatf("vec%0d_done_count", i), done_total - d0, 1);
        end

        // Reset during data bit 3 with a second byte waiting.
        cfg_nbits  = 2'b11;
        cfg_parity = 2'b00;
        cfg_stop2  = 1'b0;
        push_byte(8'h00);
        lat = 0;
        while (tx_serial !== 1'b0 && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        check("rst_mid_start_seen", int'(tx_serial === 1'b0), 1);
        in_valid = 1'b1;
        in_data  = 8'h00;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (67) @(negedge clk);
        check("rst_mid_line_low", int'(tx_serial), 0);
        d0    = done_total;
        reset = 1'b1;
        @(negedge clk);
        check("rst_mid_tx_high", int'(tx_serial), 1);
        check("rst_mid_busy", int'(tx_busy), 0);
        check("rst_mid_in_ready", int'(in_ready), 1);
        reset = 1'b0;
        lows  = 0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (tx_serial !== 1'b1 || tx_busy !== 1'b0) lows++;
        end
        check("rst_mid_buffer_discarded", lows, 0);
        check("rst_mid_no_done", done_total - d0, 0);

        // Back-to-back burst: six consecutive valid cycles.
        if (BurstPat[0]) exp_bytes[0] = burst[0];
        k = 0;
        for (int j = 0; j < 6; j++) begin
            if (BurstPat[j]) begin
                exp_bytes[k] = burst[j];
                k++;
            end
        end
        d0   = done_total;
        gap  = 0;
        line = '0;
        for (int j = 0; j < 2 + 160 * Acc + 2; j++) begin
            int n;
            n = j - 2;
            if (j < 6) begin
                check($sformatf("burst_ready%0d", j), int'(in_ready), int'(BurstPat[j]));
                in_valid = 1'b1;
                in_data  = burst[j];
            end else begin
                in_valid = 1'b0;
            end
            if (n >= 0 && n < 160 * Acc) begin
                if (n % 16 == 8) line[n / 16] = tx_serial;
                if (tx_busy !== 1'b1) gap++;
            end
            if (n == 160 * Acc) check("burst_end_idle", int'(tx_busy), 0);
            @(negedge clk);
        end
        check("burst_no_gap", gap, 0);
        for (int f = 0; f < Acc; f++) begin
            exp_f = {1'b1, exp_bytes[f], 1'b0};
            check($sformatf("burst_frame%0d", f), int'(line[f*10 +: 10]), int'(exp_f));
        end
        repeat (2) @(negedge clk);
        check("burst_done_count", done_total - d0, Acc);

        // Width change during frame 1 applies only to frame 2.
        cfg_nbits = 2'b11;
        d0    = done_total;
        line2 = '0;
        push_byte(8'hC3);
        for (int j = 0; j < 1 + 272 + 3; j++) begin
            int n;
            n = j - 1;
            if (n == 4) begin
                check("cfg_push_ready", int'(in_ready), 1);
                in_valid = 1'b1;
                in_data  = 8'hC3;
            end
            if (n == 5) in_valid = 1'b0;
            if (n == 40) cfg_nbits = 2'b00;
            if (n >= 0 && n % 16 == 8 && n / 16 < 17) line2[n / 16] = tx_serial;
            if (n == 272) check("cfg_end_idle", int'(tx_busy), 0);
            @(negedge clk);
        end
        exp2 = {1'b1, 5'b00011, 1'b0, 1'b1, 8'hC3, 1'b0};
        check("cfg_change_line", int'(line2), int'(exp2));
        check("cfg_done_count", done_total - d0, 2);

        // Baud tick every third clock: bit length follows s_tick, not clk.
        cfg_nbits  = 2'b11;
        cfg_parity = 2'b00;
        tick_every = 3;
        repeat (4) @(negedge clk);
        push_byte(8'h55);
        capture(10, frame, len, lat, done_end);
        check("slow_frame", int'(frame), 16'h02AA);
        checks++;
        if (len < 476 || len > 482) begin
            errors++;
            $display("FAIL slow_len: got %0d expected 476..482", len);
        end
        tick_every = 1;
        repeat (4) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_cfg.md
UART_TX_CFG -- requirements
Module: uart_tx_cfg

Interface
REQ-001 SHALL provide parameter NB_DATA_MAX, default 8, giving the width of in_data; legal range 5..8.
REQ-002 SHALL provide parameter S_TICK, default 16, giving the s_tick pulses per bit period.
REQ-003 SHALL provide parameter FIFO_DEPTH, default 4, giving the transmit FIFO entries; power of 2, at least 2; used only when the FIFO is compiled in.
REQ-004 SHALL have port clk  input  1  clock, all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port s_tick  input  1  baud-rate tick, one clk cycle wide.
REQ-007 SHALL have port in_valid  input  1  in_data holds a byte to send.
REQ-008 SHALL have port in_ready  output  1  block can accept a byte this cycle.
REQ-009 SHALL have port in_data  input  NB_DATA_MAX  payload, LSB first on the line.
REQ-010 SHALL have port cfg_nbits  input  2  data bits: 00=5, 01=6, 10=7, 11=8.
REQ-011 SHALL have port cfg_parity  input  2  parity: 00=none, 01=even, 10=odd, 11=none.
REQ-012 SHALL have port cfg_stop2  input  1  0 = one stop bit, 1 = two stop bits.
REQ-013 SHALL have port tx_serial  output  1  registered serial line, idle high.
REQ-014 SHALL have port tx_busy  output  1  high while the FSM is not in IDLE.
REQ-015 SHALL have port tx_done_tick  output  1  one-cycle pulse when a frame completes.

Function
REQ-016 SHALL accept a byte on each rising edge where in_valid and in_ready are both high; in_ready = buffer not full, with no combinational path from in_valid.
REQ-017 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
REQ-018 SHALL move IDLE->START when the buffer is non-empty, popping one byte and latching cfg_nbits, cfg_parity and cfg_stop2 for that frame; cfg changes mid-frame SHALL NOT affect the frame in progress.
REQ-019 SHALL drive tx_serial low on the edge the FSM enters START, i.e. one clk after acceptance when the buffer was empty and the FSM idle.
REQ-020 SHALL hold each bit for exactly S_TICK s_tick pulses; the tick counter SHALL advance only on s_tick and reset to 0 at each bit boundary.
REQ-021 SHALL send data bits LSB first in DATA, sending cfg_nbits+5 bits and ignoring higher in_data bits.
REQ-022 SHALL enter PARITY after DATA only when parity is even or odd.
REQ-023 SHALL in PARITY send the bit that makes the count of ones over the sent data bits plus parity bit even (even mode) or odd (odd mode).
REQ-024 SHALL in STOP drive 1 for S_TICK ticks, or 2*S_TICK ticks when cfg_stop2 was latched as 1.
REQ-025 SHALL pulse tx_done_tick for exactly one clk on the cycle the last stop tick is counted.
REQ-026 SHALL at the end of STOP go directly to START if the buffer is non-empty (no idle gap), otherwise to IDLE with tx_serial high.
REQ-027 SHALL never write into a full buffer; a push and a pop in the same cycle SHALL both take effect.

Reset
REQ-028 SHALL on reset set state IDLE, tx_serial=1, tx_busy=0, tx_done_tick=0, all counters 0, and the buffer empty, so in_ready=1 on the first cycle after reset.
REQ-029 SHALL on reset asserted mid-frame abort the frame, set tx_serial=1 at that edge, suppress tx_done_tick, and discard buffered bytes; reset SHALL dominate all other inputs.

Configuration
REQ-030 SHALL, when macro UART_TX_CFG_FIFO_EN is defined, buffer input in a FIFO_DEPTH-entry circular FIFO with wrap-around pointers and full/empty flags.
REQ-031 SHALL, when UART_TX_CFG_FIFO_EN is undefined, use a single holding register (in_ready = register empty) and ignore FIFO_DEPTH.

Verification
REQ-032 SHALL cover: 8N1, s_tick every clk, send 0x55 -> line 0, then 1,0,1,0,1,0,1,0, then 1, each bit 16 clk; 160 clk total; one tx_done_tick.
REQ-033 SHALL cover: 7E1, send 0x83 -> data bits 1,1,0,0,0,0,0; parity 0; bit 7 not sent; 10-bit frame.
REQ-034 SHALL cover: 5O2, send 0xFF -> five 1 data bits, parity 0, stop high for 32 ticks, then idle.
REQ-035 SHALL cover: FIFO_EN, depth 4, push 5 bytes back-to-back with FSM idle -> all 5 accepted (1 popped to FSM plus 4 buffered); 6th push sees in_ready=0; frames sent with no idle gap; 5 done pulses.
REQ-036 SHALL cover: reset asserted during DATA bit 3 -> tx_serial=1 next edge, no tx_done_tick, in_ready=1, buffer empty.
REQ-037 SHALL cover: cfg_nbits changed from 11 to 00 during DATA of frame 1 -> frame 1 sends 8 bits, frame 2 sends 5 bits.
